// File: rtl/sin_core_arbiter.sv
// Round-robin front end that shares one pipelined sine core among NREQ requesters and routes tagged results back.
// Define SIN_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sin_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 36,
  parameter int IDW     = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req,
  input  logic [32*NREQ-1:0]   i_data_in,
  output logic [NREQ-1:0]      o_grant,
  output logic [NREQ-1:0]      o_done,
  output logic [31:0]          o_result,
  output logic                 o_busy,
  output logic                 o_core_clk_en,
  output logic [31:0]          o_core_data,
  input  logic [31:0]          i_core_result
);

  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic [31:0]      r_result;
  logic [31:0]      r_core_data;
  // Stage 0 holds the tag of the operand currently on core_data; stage LATENCY lines up with core_result.
  logic [LATENCY:0] r_tag_v;
  logic [IDW-1:0]   r_tag_id [0:LATENCY];

  logic [NREQ-1:0]  w_elig;
  logic             w_win;
  logic [IDW-1:0]   w_win_id;
  logic [31:0]      w_data;
  logic             w_en;
  logic             w_ret;
  logic [NREQ-1:0]  w_grant_1h;
  logic [NREQ-1:0]  w_done_1h;

  // A requester granted this cycle is excluded so its req can settle before the next operand.
  assign w_elig = i_req & ~r_grant;

`ifdef SIN_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win    = 1'b0;
    w_win_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_win    = 1'b1;
        w_win_id = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0]    r_ptr;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW:0]      w_sum;

  assign w_dbl = {w_elig, w_elig} >> r_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  // w_rot[k] is requester (r_ptr + k) mod NREQ; the lowest set k is the round-robin winner.
  always_comb begin
    w_win    = 1'b0;
    w_win_id = '0;
    w_sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_win && w_rot[k]) begin
        w_win = 1'b1;
        w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NREQ)) begin
          w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_win_id = w_sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (w_win) begin
      r_ptr <= (w_win_id == IDW'(NREQ - 1)) ? '0 : w_win_id + 1'b1;
    end
  end
`endif

  always_comb begin
    w_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win_id == IDW'(k)) begin
        w_data = i_data_in[32*k +: 32];
      end
    end
  end

  assign w_grant_1h = NREQ'(1) << w_win_id;
  assign w_done_1h  = NREQ'(1) << r_tag_id[LATENCY];

  // The core only advances while something is in flight, so the tag pipe shifts on the same enables.
  assign w_en  = (|r_grant) | (|r_tag_v);
  assign w_ret = w_en & r_tag_v[LATENCY];

  always_ff @(posedge i_clock) begin
    if (w_en) begin
      for (int k = LATENCY; k >= 1; k--) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
    r_tag_id[0] <= w_win_id;

    if (i_reset) begin
      r_grant     <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_core_data <= '0;
      r_tag_v     <= '0;
    end else begin
      r_grant <= w_win ? w_grant_1h : '0;
      if (w_win) begin
        r_core_data <= w_data;
      end
      if (w_en) begin
        r_tag_v <= {r_tag_v[LATENCY-1:0], w_win};
      end else begin
        r_tag_v[0] <= w_win;
      end
      r_done <= w_ret ? w_done_1h : '0;
      if (w_ret) begin
        r_result <= i_core_result;
      end
    end
  end

  assign o_grant       = r_grant;
  assign o_done        = r_done;
  assign o_result      = r_result;
  assign o_busy        = |r_tag_v;
  assign o_core_clk_en = w_en;
  assign o_core_data   = r_core_data;

endmodule

// File: tb/tb_sin_core_arbiter.sv
// Directed bench for sin_core_arbiter with a stand-in pipelined core; follows SIN_ARB_FIXED_PRIO_EN when defined.
module tb_sin_core_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 36;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] data_in;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [31:0]       result;
  logic              busy;
  logic              core_clk_en;
  logic [31:0]       core_data;
  logic [31:0]       core_result;

  logic [31:0] dat [0:NREQ-1];
  logic [31:0] core_pipe [0:LAT-1];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [31:0] last_exp = 32'h0;

  int          infl_cyc [$];
  logic [2:0]  infl_id  [$];
  logic [31:0] infl_dat [$];
  int          gq       [$];

  sin_core_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .IDW(3)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_data_in    (data_in),
    .o_grant      (grant),
    .o_done       (done),
    .o_result     (result),
    .o_busy       (busy),
    .o_core_clk_en(core_clk_en),
    .o_core_data  (core_data),
    .i_core_result(core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_in = {dat[3], dat[2], dat[1], dat[0]};

  // Stand-in for the sine core: sin(pi/2)=1.0 exactly, any other operand gets a distinguishable transform.
  function automatic logic [31:0] model_sin(input logic [31:0] d);
    if (d == 32'h3FC90FDB) return 32'h3F800000;
    return d ^ 32'hA5A5A5A5;
  endfunction

  initial begin
    for (int k = 0; k < LAT; k++) core_pipe[k] = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (core_clk_en) begin
      core_pipe[0] <= model_sin(core_data);
      for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
  end
  assign core_result = core_pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every grant is expected back as a done exactly LAT+1 cycles later, in issue order.
  always @(negedge clk) begin
    int gid;
    cyc++;
    if (rst) begin
      infl_cyc.delete();
      infl_id.delete();
      infl_dat.delete();
    end else begin
      if (grant != '0) begin
        gid = 0;
        for (int k = 0; k < NREQ; k++) if (grant[k]) gid = k;
        chk("grant_onehot", 32'($onehot(grant)), 32'd1);
        chk("core_data", core_data, dat[gid]);
        infl_cyc.push_back(cyc);
        infl_id.push_back(3'(gid));
        infl_dat.push_back(dat[gid]);
        gq.push_back(gid);
        $display("cycle %0d: grant[%0d] data %h", cyc, gid, dat[gid]);
      end
      if (done != '0) begin
        if (infl_id.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          int    gc;
          logic [2:0]  id;
          logic [31:0] d;
          gc = infl_cyc.pop_front();
          id = infl_id.pop_front();
          d  = infl_dat.pop_front();
          last_exp = model_sin(d);
          chk("done_id", 32'(done), 32'(4'b0001 << id));
          chk("done_latency", cyc - gc, LAT + 1);
          chk("done_result", result, last_exp);
          $display("cycle %0d: done[%0d] result %h", cyc, id, result);
        end
      end
      chk("busy", 32'(busy), 32'(infl_id.size() != 0));
      chk("core_clk_en", 32'(core_clk_en), 32'(infl_id.size() != 0));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [NREQ-1:0] mask, input int hold);
    @(posedge clk); #1 req = mask;
    repeat (hold) @(posedge clk);
    #1 req = '0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 200 && infl_id.size() != 0; k++) @(negedge clk);
    #1 chk("drain_timeout", 32'(infl_id.size()), 32'd0);
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [NREQ-1:0] mask;
    int              hold;
    string           seq;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{4'b0100, 1,  "2"};
    vecs[1] = '{4'b1111, 4,
`ifdef SIN_ARB_FIXED_PRIO_EN
                "0101"};
`else
                "0123"};
`endif
    vecs[2] = '{4'b0010, 10, "11111"};
    vecs[3] = '{4'b1001, 6,  "030303"};
    vecs[4] = '{4'b1011, 6,
`ifdef SIN_ARB_FIXED_PRIO_EN
                "010101"};
`else
                "013013"};
`endif
    vecs[5] = '{4'b0011, 1,  "0"};

    dat[0] = 32'h40490FDB;
    dat[1] = 32'h3F000000;
    dat[2] = 32'h3FC90FDB;
    dat[3] = 32'hBF800000;
    rst = 1'b1;
    req = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_en", 32'(core_clk_en), 32'd0);
    chk("rst_core_data", core_data, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      gq.delete();
      pulse_req(vecs[i].mask, vecs[i].hold);
      drain();
      chk("grant_count", 32'(gq.size()), 32'(vecs[i].seq.len()));
      for (int k = 0; k < gq.size() && k < vecs[i].seq.len(); k++) begin
        chk("grant_order", 32'(gq[k]), 32'(vecs[i].seq[k] - "0"));
      end
      chk("result_held", result, last_exp);
      if (i == 0) chk("pi2_result", result, 32'h3F800000);
      $display("vector %0d: mask %b hold %0d grants %0d", i, vecs[i].mask, vecs[i].hold, gq.size());
    end

    // Reset 10 cycles after a grant: that operation must never complete.
    do_reset();
    gq.delete();
    pulse_req(4'b0100, 1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_clk_en", 32'(core_clk_en), 32'd0);
    chk("midrst_core_data", core_data, 32'd0);
    repeat (60) @(negedge clk);
    gq.delete();
    pulse_req(4'b0001, 1);
    drain();
    chk("post_rst_grants", 32'(gq.size()), 32'd1);
    chk("post_rst_result", result, model_sin(dat[0]));
    $display("mid-operation reset sequence complete");

    // Gap mid-stream: the core stays enabled until the pipe empties, then freezes.
    do_reset();
    gq.delete();
    pulse_req(4'b0001, 1);
    repeat (5) @(posedge clk);
    #1 chk("gap_clk_en", 32'(core_clk_en), 32'd1);
    pulse_req(4'b1000, 1);
    drain();
    chk("gap_grants", 32'(gq.size()), 32'd2);
    chk("idle_clk_en", 32'(core_clk_en), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("gap_result", result, model_sin(dat[3]));
    $display("gap sequence complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
